score_render: RTL and testbench

SCORE_RENDER -- requirements
Module: score_render

---
 rtl/score_pkg.sv | 27 ++
 rtl/score_digit_rom.sv | 52 +++++
 rtl/score_render.sv | 216 +++++++++++++++++++++
 tb/tb_score_render.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score renderer: glyph geometry,
// BCD digit type, conversion FSM states and glyph ROM address.
package score_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [11:0] rom_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // Elaboration-time 10**n, used for the saturation threshold.
    function automatic int unsigned pow10(input int n);
        int unsigned v;
        v = 32'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 32'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/score_digit_rom.sv
// 4096x4 glyph ROM for digits 0-9, address {digit, row, col}, synchronous read.
// Glyphs are seven-segment shapes; opaque pixels carry palette index digit+1.
module score_digit_rom
    import score_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  rom_addr_t  addr,
    output logic [3:0] data
);

    function automatic logic [3:0] glyph_px(input rom_addr_t a);
        logic [6:0] seg;
        logic [3:0] r;
        logic [3:0] c;
        logic       lit;
        r = a[7:4];
        c = a[3:0];
        // segment order {a,b,c,d,e,f,g}
        case (a[11:8])
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h70;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
            default: seg = 7'h00;
        endcase
        lit = (seg[6] & (r <= 4'd1))
            | (seg[5] & (c >= 4'd14) & (r <= 4'd8))
            | (seg[4] & (c >= 4'd14) & (r >= 4'd7))
            | (seg[3] & (r >= 4'd14))
            | (seg[2] & (c <= 4'd1) & (r >= 4'd7))
            | (seg[1] & (c <= 4'd1) & (r <= 4'd8))
            | (seg[0] & ((r == 4'd7) | (r == 4'd8)));
        return lit ? (a[11:8] + 4'd1) : 4'd0;
    endfunction

    // Registered ROM read
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            data <= 4'd0;
        end else begin
            data <= glyph_px(addr);
        end
    end

endmodule

// File: rtl/score_render.sv
// Binary score -> BCD (double dabble) and 3-stage glyph pixel pipeline.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN hides leading zero digits.
module score_render
    import score_pkg::*;
#(
    parameter int         DIGITS     = 4,
    parameter int         SCORE_W    = 14,
    parameter logic [9:0] X0         = 10'd16,
    parameter logic [9:0] Y0         = 10'd16,
    parameter int         SCALE_LOG2 = 1
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    output logic               busy,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    output logic               pixel_hit,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);

    localparam int          BCD_N   = ((SCORE_W + 2) / 3 > DIGITS) ? (SCORE_W + 2) / 3 : DIGITS;
    localparam int          ACC_W   = 4 * BCD_N;
    localparam int          CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

    fsm_state_t         r_state;
    logic [SCORE_W-1:0] r_bin;
    logic [ACC_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    bcd_digit_t         r_digits [DIGITS];

    logic [ACC_W-1:0]         w_adj;
    logic [ACC_W+SCORE_W-1:0] w_shift;

    // Add-3 correction on every nibble >= 5 ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < BCD_N; k++) begin
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3) : r_bcd[4*k +: 4];
        end
    end

    assign w_shift = {w_adj, r_bin} << 1;

    // Conversion FSM; displayed digits change only in DONE
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                r_digits[d] <= 4'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (score_load) begin
                        r_bin   <= score;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_sat   <= (32'(score) > MAX_VAL);
                        r_state <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_shift[ACC_W+SCORE_W-1 -: ACC_W];
                    r_bin <= w_shift[SCORE_W-1:0];
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    for (int d = 0; d < DIGITS; d++) begin
                        r_digits[d] <= r_sat ? 4'd9 : r_bcd[4*(DIGITS-1-d) +: 4];
                    end
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    logic [9:0] w_xs;
    logic [9:0] w_ys;
    logic [5:0] w_slot;
    logic [3:0] w_col;
    logic [3:0] w_row;
    logic       w_in_field;
    logic       w_lead_blank;
    bcd_digit_t w_digit;

    // A coordinate is in range when its scaled offset fits the slot/row count
    assign w_xs       = (DrawX - X0) >> SCALE_LOG2;
    assign w_ys       = (DrawY - Y0) >> SCALE_LOG2;
    assign w_slot     = w_xs[9:4];
    assign w_col      = w_xs[3:0];
    assign w_row      = w_ys[3:0];
    assign w_in_field = (DrawX >= X0) && (w_slot < 6'(DIGITS))
                     && (DrawY >= Y0) && (w_ys < 10'(GLYPH_H))
                     && !w_lead_blank;

    // Select the displayed digit for the current slot
    always_comb begin
        w_digit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            w_digit = (w_slot == 6'(d)) ? r_digits[d] : w_digit;
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    // A slot is blanked when it and every more significant digit are zero
    always_comb begin
        logic v_zero_run;
        v_zero_run   = 1'b1;
        w_lead_blank = 1'b0;
        for (int d = 0; d < DIGITS - 1; d++) begin
            v_zero_run   = v_zero_run & (r_digits[d] == 4'd0);
            w_lead_blank = w_lead_blank | ((w_slot == 6'(d)) & v_zero_run);
        end
    end
`else
    assign w_lead_blank = 1'b0;
`endif

    rom_addr_t  r_s1_addr;
    logic       r_s1_infield;
    logic       r_s1_blank;
    logic       r_s2_infield;
    logic       r_s2_blank;
    logic [3:0] w_rom_data;
    logic [11:0] w_rgb;

    // S1: field flag, blank and ROM address
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_s1_addr    <= '0;
            r_s1_infield <= 1'b0;
            r_s1_blank   <= 1'b0;
        end else begin
            r_s1_addr    <= {w_digit, w_row, w_col};
            r_s1_infield <= w_in_field;
            r_s1_blank   <= blank;
        end
    end

    score_digit_rom u_rom (
        .vga_clk (vga_clk),
        .reset   (reset),
        .addr    (r_s1_addr),
        .data    (w_rom_data)
    );

    // S2: keep qualifiers aligned with the ROM read
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_s2_infield <= 1'b0;
            r_s2_blank   <= 1'b0;
        end else begin
            r_s2_infield <= r_s1_infield;
            r_s2_blank   <= r_s1_blank;
        end
    end

    // Palette: index 0 transparent, 1..10 are digit colours
    always_comb begin
        case (w_rom_data)
            4'd0:    w_rgb = 12'h000;
            4'd1:    w_rgb = 12'hF00;
            4'd2:    w_rgb = 12'hF80;
            4'd3:    w_rgb = 12'hFF0;
            4'd4:    w_rgb = 12'h8F0;
            4'd5:    w_rgb = 12'h0F0;
            4'd6:    w_rgb = 12'h0F8;
            4'd7:    w_rgb = 12'h0FF;
            4'd8:    w_rgb = 12'h08F;
            4'd9:    w_rgb = 12'h00F;
            4'd10:   w_rgb = 12'hF0F;
            4'd11:   w_rgb = 12'h888;
            4'd12:   w_rgb = 12'h444;
            4'd13:   w_rgb = 12'hCCC;
            4'd14:   w_rgb = 12'h246;
            4'd15:   w_rgb = 12'hFFF;
            default: w_rgb = 12'h000;
        endcase
    end

    // S3: registered colour output
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
            pixel_hit          <= 1'b0;
        end else if (r_s2_blank && r_s2_infield && (w_rom_data != 4'd0)) begin
            {red, green, blue} <= w_rgb;
            pixel_hit          <= 1'b1;
        end else begin
            {red, green, blue} <= 12'h000;
            pixel_hit          <= 1'b0;
        end
    end

endmodule

// File: tb/tb_score_render.sv
// Self-checking bench for score_render: cycle-level behavioural model of the
// conversion and pixel rendering, compared with the DUT every cycle.
module tb_score_render;

    localparam int         DIGITS     = 4;
    localparam int         SCORE_W    = 14;
    localparam int         SCALE_LOG2 = 1;
    localparam logic [9:0] X0         = 10'd16;
    localparam logic [9:0] Y0         = 10'd16;
    localparam int         SC         = 1 << SCALE_LOG2;
    localparam int         GW         = 16 * SC;
    localparam int         FW         = DIGITS * GW;
    localparam int         FH         = GW;

    logic               vga_clk;
    logic               reset;
    logic [SCORE_W-1:0] score;
    logic               score_load;
    logic               busy;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               blank;
    logic               pixel_hit;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;

    score_render #(
        .DIGITS     (DIGITS),
        .SCORE_W    (SCORE_W),
        .X0         (X0),
        .Y0         (Y0),
        .SCALE_LOG2 (SCALE_LOG2)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .score      (score),
        .score_load (score_load),
        .busy       (busy),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .pixel_hit  (pixel_hit),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;

    logic [11:0] pal [16] = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h8F0, 12'h0F0, 12'h0F8, 12'h0FF,
                              12'h08F, 12'h00F, 12'hF0F, 12'h888, 12'h444, 12'hCCC, 12'h246, 12'hFFF};
    string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ipow10(input int n);
        int v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    function automatic bit glyph_lit(input int dig, input int row, input int col);
        string s = seg_tab[dig];
        bit    on = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": on |= (row <= 1);
                "b": on |= (col >= 14 && row <= 8);
                "c": on |= (col >= 14 && row >= 7);
                "d": on |= (row >= 14);
                "e": on |= (col <= 1 && row >= 7);
                "f": on |= (col <= 1 && row <= 8);
                "g": on |= (row == 7 || row == 8);
                default: on |= 1'b0;
            endcase
        end
        return on;
    endfunction

    // Expected {pixel_hit, rgb} for one pixel given the shown score value
    function automatic logic [12:0] model_pixel(input int x, input int y, input bit bl, input int shown);
        int fx, fy, slot, col, row, p10, dig;
        fx = x - int'(X0);
        fy = y - int'(Y0);
        if (!bl || fx < 0 || fx >= FW || fy < 0 || fy >= FH) return 13'd0;
        slot = fx / GW;
        col  = (fx / SC) % 16;
        row  = fy / SC;
        p10  = ipow10(DIGITS - 1 - slot);
        dig  = (shown / p10) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (slot != DIGITS - 1 && shown < p10) return 13'd0;
`endif
        if (!glyph_lit(dig, row, col)) return 13'd0;
        return {1'b1, pal[dig + 1]};
    endfunction

    int          m_busy_cnt = 0;
    int          m_pending  = 0;
    int          m_shown    = 0;
    logic [12:0] m_p0 = 13'd0, m_p1 = 13'd0, m_p2 = 13'd0;

    // Model update at each rising edge, compare 1 time unit later
    initial begin
        forever begin
            @(posedge vga_clk);
            if (reset) begin
                m_busy_cnt = 0;
                m_shown    = 0;
                m_p0 = 13'd0; m_p1 = 13'd0; m_p2 = 13'd0;
            end else begin
                m_p2 = m_p1;
                m_p1 = m_p0;
                m_p0 = model_pixel(int'(DrawX), int'(DrawY), blank, m_shown);
                if (m_busy_cnt == 0) begin
                    if (score_load) begin
                        m_pending  = int'(score);
                        m_busy_cnt = SCORE_W + 1;
                    end
                end else begin
                    m_busy_cnt--;
                    if (m_busy_cnt == 0) m_shown = (m_pending > 9999) ? 9999 : m_pending;
                end
            end
            #1;
            check("busy_model", 32'(busy), 32'(m_busy_cnt != 0));
            check("pixel_model", 32'({pixel_hit, red, green, blue}), 32'(m_p2));
        end
    end

    bit auto_scan = 1'b1;
    int scan_k    = 0;

    task automatic step();
        @(negedge vga_clk);
        if (auto_scan) begin
            scan_k++;
            DrawX = 10'(int'(X0) - 3 + (scan_k * 7) % (FW + 6));
            DrawY = 10'(int'(Y0) - 1 + (scan_k * 5) % (FH + 2));
            blank = (scan_k % 9) != 0;
        end
    endtask

    task automatic do_load(input int v);
        score      = SCORE_W'(v);
        score_load = 1'b1;
        step();
        score_load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive one pixel after an off-field pause; check it lands exactly 3 cycles later
    task automatic probe(input int x, input int y, input bit eh, input logic [11:0] ergb, input string nm);
        auto_scan = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1;
        wait_cycles(3);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        check({nm, "_lat1"}, 32'(pixel_hit), 32'd0);
        step();
        check({nm, "_lat2"}, 32'(pixel_hit), 32'd0);
        step();
        check({nm, "_hit"}, 32'(pixel_hit), 32'(eh));
        check({nm, "_rgb"}, 32'({red, green, blue}), 32'(ergb));
        auto_scan = 1'b1;
    endtask

    task automatic sweep();
        auto_scan = 1'b0;
        for (int y = int'(Y0) - 1; y <= int'(Y0) + FH + 1; y += 2) begin
            for (int x = int'(X0) - 1; x <= int'(X0) + FW; x++) begin
                DrawX = 10'(x);
                DrawY = 10'(y);
                blank = ((x + y) % 11) != 0;
                step();
            end
        end
        auto_scan = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        reset = 1'b1; score = '0; score_load = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hit", 32'(pixel_hit), 32'd0);
        check("reset_rgb", 32'({red, green, blue}), 32'd0);

        // 1234: busy for 15 cycles, digits after 16
        do_load(1234);
        check("busy_rise", 32'(busy), 32'd1);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            busy_cycles += int'(busy);
            step();
        end
        check("busy_len_1234", 32'(busy_cycles), 32'd15);
        check("model_1234", 32'(m_shown), 32'd1234);
        sweep();

        // Saturation and boundary values
        do_load(16383);
        wait_cycles(20);
        check("model_16383", 32'(m_shown), 32'd9999);
        probe(int'(X0), int'(Y0), 1'b1, 12'hF0F, "sat_slot0");
        sweep();
        do_load(10000);
        wait_cycles(20);
        do_load(9999);
        wait_cycles(20);

        // Second load during conversion is dropped
        do_load(5678);
        wait_cycles(4);
        do_load(1111);
        wait_cycles(20);
        check("model_ignore", 32'(m_shown), 32'd5678);
        probe(int'(X0), int'(Y0), 1'b1, 12'h0F8, "origin");
        probe(int'(X0) - 1, int'(Y0), 1'b0, 12'h000, "left_edge");
        probe(int'(X0) + FW, int'(Y0), 1'b0, 12'h000, "right_edge");

        // Leading zeros
        do_load(7);
        wait_cycles(20);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        probe(int'(X0), int'(Y0), 1'b0, 12'h000, "lead0_slot0");
`else
        probe(int'(X0), int'(Y0), 1'b1, 12'hF00, "lead0_slot0");
`endif
        probe(int'(X0) + 3 * GW, int'(Y0), 1'b1, 12'h08F, "seven_slot3");
        sweep();

        // Reset in the middle of SHIFT
        do_load(3333);
        wait_cycles(6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("model_midreset", 32'(m_shown), 32'd0);
        probe(int'(X0) + 3 * GW, int'(Y0), 1'b1, 12'hF00, "zero_slot3");
        do_load(42);
        wait_cycles(20);
        probe(int'(X0) + 2 * GW, int'(Y0), 1'b1, 12'h0F0, "42_slot2");
        probe(int'(X0) + 3 * GW, int'(Y0), 1'b1, 12'hFF0, "42_slot3");
        sweep();

        wait_cycles(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
